// File: rtl/muldiv_hilo_ctrl_pkg.sv
// muldiv_hilo_ctrl_pkg: shared op/state encodings and datapath width
package muldiv_hilo_ctrl_pkg;
  localparam int W = 32;
  typedef enum logic [2:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MF
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_MUL_WB, S_DIV_START, S_DIV_WAIT, S_DIV_DRAIN
  } state_e;
endpackage

// File: rtl/muldiv_hilo_ctrl_mul.sv
// mul_pipe: one-stage registered 32x32 signed/unsigned multiply
//   clk, rst (async, active-high); en loads prod; sgn selects signed
//   a, b: operands; prod: registered 64-bit product
module mul_pipe
  import muldiv_hilo_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           sgn,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod
);
  logic [2*W-1:0] w_a, w_b, r_prod;
  // extend to 64 bits; the low 64 bits of the product are then right for either signedness
  assign w_a  = {{W{sgn & a[W-1]}}, a};
  assign w_b  = {{W{sgn & b[W-1]}}, b};
  assign prod = r_prod;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_prod <= '0;
    else if (en) r_prod <= w_a * w_b;
endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: multiply/divide sequencer and HI/LO register file
//   clk, rst (async, active-high)
//   op_valid/op/rs_val/rt_val: request from EX; flush cancels in-flight work
//   stall: EX hold; hi/lo: architectural registers
//   div_en/div_hassign/div_a/div_b -> external divider; div_q/div_r/div_busy/div_done <- divider
//   div_zero: divide-by-zero pulse, only active when DIV_ZERO_CHECK_EN is defined
module muldiv_hilo_ctrl
  import muldiv_hilo_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  input  logic [2:0]   op,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  input  logic         flush,
  output logic         stall,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         div_en,
  output logic         div_hassign,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r,
  input  logic         div_busy,
  input  logic         div_done,
  output logic         div_zero
);
  state_e         r_state, w_next;
  op_e            w_op;
  logic           w_acc, w_mul, w_isdiv, w_div, w_zero, w_wr_mul, w_wr_div;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   r_hi, r_lo, r_a, r_b;
  logic           r_sgn, r_div_zero;
  assign w_op    = op_e'(op);
  assign w_acc   = op_valid && !flush && r_state == S_IDLE;
  assign w_mul   = w_acc && (w_op == OP_MULT || w_op == OP_MULTU);
  assign w_isdiv = w_acc && (w_op == OP_DIV || w_op == OP_DIVU);
`ifdef DIV_ZERO_CHECK_EN
  assign w_zero = rt_val == '0;
`else
  assign w_zero = 1'b0;
`endif
  assign w_div       = w_isdiv && !w_zero;
  assign stall       = op_valid && r_state != S_IDLE;
  // a flush in DIV_START suppresses the start pulse combinationally
  assign div_en      = r_state == S_DIV_START && !flush;
  assign w_wr_mul    = r_state == S_MUL && !flush;
  assign w_wr_div    = r_state == S_DIV_WAIT && div_done && !flush;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_a       = r_a;
  assign div_b       = r_b;
  assign div_hassign = r_sgn;
  assign div_zero    = r_div_zero;
  mul_pipe u_mul (
    .clk (clk),
    .rst (rst),
    .en  (w_mul),
    .sgn (w_op == OP_MULT),
    .a   (rs_val),
    .b   (rt_val),
    .prod(w_prod)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = w_mul ? S_MUL : w_div ? S_DIV_START : S_IDLE;
      S_MUL:       w_next = flush ? S_IDLE : S_MUL_WB;
      S_MUL_WB:    w_next = S_IDLE;
      S_DIV_START: w_next = flush ? S_IDLE : S_DIV_WAIT;
      // flush beats a same-cycle div_done: the result is dropped and no drain is needed
      S_DIV_WAIT:  w_next = div_done ? S_IDLE : flush ? S_DIV_DRAIN : S_DIV_WAIT;
      S_DIV_DRAIN: w_next = div_done ? S_IDLE : S_DIV_DRAIN;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= S_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sgn      <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_div_zero <= w_isdiv && w_zero;
      if (w_acc && w_op == OP_MTHI) r_hi <= rs_val;
      if (w_acc && w_op == OP_MTLO) r_lo <= rs_val;
      if (w_wr_mul) {r_hi, r_lo} <= w_prod;
      if (w_wr_div) begin
        r_lo <= div_q;
        r_hi <= div_r;
      end
      if (w_div) begin
        r_a   <= rs_val;
        r_b   <= rt_val;
        r_sgn <= w_op == OP_DIV;
      end
    end
  a_no_en_busy: assert property (@(posedge clk) disable iff (rst) !(div_en && div_busy));
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: table, corner-case and randomized checks of muldiv_hilo_ctrl
module tb_muldiv_hilo_ctrl;
  import muldiv_hilo_ctrl_pkg::*;
  localparam int DLAT = 32;
  logic        clk, rst, op_valid, flush, stall, div_en, div_hassign, div_busy, div_done, div_zero;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val, hi, lo, div_a, div_b, div_q, div_r;
  int ncmp = 0, nbad = 0, n_en = 0;

  muldiv_hilo_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .stall(stall), .hi(hi), .lo(lo), .div_en(div_en), .div_hassign(div_hassign),
    .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r), .div_busy(div_busy),
    .div_done(div_done), .div_zero(div_zero)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic s);
    if (b == 0) return {32'hFFFFFFFF, a};
    if (s) return {32'(int'(a) / int'(b)), 32'(int'(a) % int'(b))};
    return {a / b, a % b};
  endfunction

  function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic s);
    if (s) return 64'(longint'(int'(a)) * longint'(int'(b)));
    return 64'(longint'({32'b0, a}) * longint'({32'b0, b}));
  endfunction

  // behavioural iterative divider: fixed latency, one-cycle done with q/r
  int          dcnt;
  logic [31:0] ma, mb;
  logic        ms;
  always @(posedge clk or posedge rst)
    if (rst) begin
      div_busy <= 0; div_done <= 0; dcnt <= 0; div_q <= 0; div_r <= 0;
    end else begin
      div_done <= 0;
      if (div_en) begin
        ma <= div_a; mb <= div_b; ms <= div_hassign; div_busy <= 1; dcnt <= DLAT;
      end else if (div_busy) begin
        if (dcnt == 1) begin
          div_busy <= 0; div_done <= 1; {div_q, div_r} <= ref_div(ma, mb, ms);
        end
        dcnt <= dcnt - 1;
      end
    end

  always @(posedge clk) if (div_en) n_en++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // issue one op, then hold MFLO until stall drops; w counts stalled cycles,
  // fat is the cycle (0 = request cycle) at which flush is pulsed, -1 for none
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int fat, output int w);
    int c;
    w = 0;
    @(negedge clk);
    op_valid = 1; op = o; rs_val = a; rt_val = b; flush = (fat == 0);
    @(negedge clk);
    op = OP_MF; c = 1; flush = (c == fat); #1;
    while (stall && w < 400) begin
      w++;
      @(negedge clk);
      c++; flush = (c == fat); #1;
    end
    flush = 0; op_valid = 0;
  endtask

  function automatic int exp_wait(logic [2:0] o);
    if (o == OP_MULT || o == OP_MULTU) return 2;
    if (o == OP_DIV || o == OP_DIVU) return DLAT + 2;
    return 0;
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          waits, ens;
  } vec_t;
  vec_t tv[6];

  initial begin
    int w, e0;
    logic [31:0] mhi, mlo, a, b;
    logic [2:0] o;
    logic [2:0] ops[6];
    tv[0] = '{OP_MTHI,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0,        0,        0};
    tv[1] = '{OP_MTLO,  32'h1,        32'h0, 32'hDEADBEEF, 32'h1,        0,        0};
    tv[2] = '{OP_MULT,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 2,        0};
    tv[3] = '{OP_MULTU, 32'hFFFFFFFE, 32'h3, 32'h2,        32'hFFFFFFFA, 2,        0};
    tv[4] = '{OP_DIV,   32'hFFFFFF9C, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFF2, DLAT + 2, 1};
    tv[5] = '{OP_DIVU,  32'h9,        32'h2, 32'h1,        32'h4,        DLAT + 2, 1};
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
    rst = 1; op_valid = 0; op = OP_NONE; rs_val = 0; rt_val = 0; flush = 0;
    #1;
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_stall", stall, 0);
    chk("rst_div_en", div_en, 0); chk("rst_hassign", div_hassign, 0);
    chk("rst_div_a", div_a, 0); chk("rst_div_b", div_b, 0); chk("rst_div_zero", div_zero, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    for (int i = 0; i < 6; i++) begin
      e0 = n_en;
      run_op(tv[i].op, tv[i].a, tv[i].b, -1, w);
      chk($sformatf("tv%0d_hi", i), hi, tv[i].hi);
      chk($sformatf("tv%0d_lo", i), lo, tv[i].lo);
      chk($sformatf("tv%0d_wait", i), w, tv[i].waits);
      chk($sformatf("tv%0d_en", i), n_en - e0, tv[i].ens);
    end

    @(negedge clk);
    op_valid = 1; op = OP_MULT; rs_val = 5; rt_val = 7;
    @(negedge clk);
    op_valid = 0;
    chk("mul_c1_hi", hi, 1); chk("mul_c1_lo", lo, 4);
    @(negedge clk);
    chk("mul_c2_hi", hi, 0); chk("mul_c2_lo", lo, 35);

    run_op(OP_MULT, 9, 9, 1, w);
    chk("flush_mul_wait", w, 1); chk("flush_mul_hi", hi, 0); chk("flush_mul_lo", lo, 35);
    run_op(OP_MTHI, 32'h12345678, 0, 0, w);
    chk("flush_req_wait", w, 0); chk("flush_req_hi", hi, 0);
    e0 = n_en;
    run_op(OP_DIV, 100, 7, 1, w);
    chk("flush_start_wait", w, 1); chk("flush_start_en", n_en - e0, 0);
    chk("flush_start_lo", lo, 35);
    e0 = n_en;
    run_op(OP_DIV, 100, 7, 5, w);
    chk("flush_wait_wait", w, DLAT + 2); chk("flush_wait_en", n_en - e0, 1);
    chk("flush_wait_hi", hi, 0); chk("flush_wait_lo", lo, 35);
    run_op(OP_DIVU, 9, 2, -1, w);
    chk("after_flush_hi", hi, 1); chk("after_flush_lo", lo, 4);

`ifdef DIV_ZERO_CHECK_EN
    e0 = n_en;
    @(negedge clk);
    op_valid = 1; op = OP_DIVU; rs_val = 5; rt_val = 0;
    @(negedge clk);
    op = OP_MF; #1;
    chk("zero_pulse", div_zero, 1); chk("zero_stall", stall, 0);
    @(negedge clk);
    op_valid = 0; #1;
    chk("zero_clear", div_zero, 0); chk("zero_en", n_en - e0, 0);
    chk("zero_hi", hi, 1); chk("zero_lo", lo, 4);
`else
    run_op(OP_DIVU, 5, 0, -1, w);
    chk("zero_wait", w, DLAT + 2); chk("zero_hi", hi, 5); chk("zero_lo", lo, 32'hFFFFFFFF);
    chk("zero_pulse", div_zero, 0);
`endif

    @(negedge clk);
    op_valid = 1; op = OP_DIV; rs_val = 32'hFFFFFF9C; rt_val = 7;
    @(negedge clk);
    op = OP_MF; #1;
    chk("mid_div_en", div_en, 1); chk("mid_div_a", div_a, 32'hFFFFFF9C);
    chk("mid_div_b", div_b, 7); chk("mid_hassign", div_hassign, 1);
    repeat (8) @(negedge clk);
    rst = 1; #1;
    chk("mid_rst_hi", hi, 0); chk("mid_rst_lo", lo, 0); chk("mid_rst_stall", stall, 0);
    chk("mid_rst_en", div_en, 0); chk("mid_rst_hassign", div_hassign, 0);
    chk("mid_rst_a", div_a, 0); chk("mid_rst_b", div_b, 0); chk("mid_rst_zero", div_zero, 0);
    @(negedge clk);
    rst = 0; op_valid = 0;
    run_op(OP_DIV, 32'hFFFFFF9C, 7, -1, w);
    chk("post_rst_wait", w, DLAT + 2);
    chk("post_rst_hi", hi, 32'hFFFFFFFE); chk("post_rst_lo", lo, 32'hFFFFFFF2);

    mhi = 32'hFFFFFFFE; mlo = 32'hFFFFFFF2;
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (o == OP_DIV || o == OP_DIVU) begin
        if (b == 0) b = 1;
        if (o == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 3;
        {mlo, mhi} = ref_div(a, b, o == OP_DIV);
      end else if (o == OP_MULT || o == OP_MULTU) {mhi, mlo} = ref_mul(a, b, o == OP_MULT);
      else if (o == OP_MTHI) mhi = a;
      else mlo = a;
      run_op(o, a, b, -1, w);
      chk($sformatf("rnd%0d_hi", i), hi, mhi);
      chk($sformatf("rnd%0d_lo", i), lo, mlo);
      chk($sformatf("rnd%0d_wait", i), w, exp_wait(o));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
